// File: rtl/candy_avb_pio_pkg.sv
// candy_avb_pio_pkg
//   Shared register map and sizing helpers for the Avalon-MM PIO input block.
//   Imported by candy_avb_test_qsys_pio_in.
package candy_avb_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;  // filtered input value, read-only
  localparam logic [1:0] ADDR_RSVD = 2'd1;  // reserved, reads 0
  localparam logic [1:0] ADDR_MASK = 2'd2;  // irq mask, read/write
  localparam logic [1:0] ADDR_EDGE = 2'd3;  // edge capture, write-1-to-clear

  // Start-up counter must reach sync_stages+1; two bits cover the default depth.
  function automatic int unsigned startup_cnt_w(input int unsigned sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/candy_avb_pio_in_filter.sv
// candy_avb_pio_in_filter
//   One input bit: SYNC_STAGES-deep synchronizer, optionally followed by a
//   debounce filter when PIO_IN_DEBOUNCE_EN is defined.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   i_async  - asynchronous external input bit
//   o_filt   - synchronized (and debounced, if enabled) value
// Configuration macro: PIO_IN_DEBOUNCE_EN
module candy_avb_pio_in_filter #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef PIO_IN_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CNT = 1000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_filt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  logic            r_filt;
  logic [CntW-1:0] r_cnt;

  // Filtered value follows only after DEBOUNCE_CNT consecutive disagreeing clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_filt = r_filt;
`else
  assign o_filt = w_sync;
`endif

endmodule

// File: rtl/candy_avb_test_qsys_pio_in.sv
// candy_avb_test_qsys_pio_in
//   Avalon-MM slave PIO input port with synchronizer, optional debounce,
//   rising-edge capture and masked level interrupt.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM slave write/select interface
//   readdata              - combinational read data, zero-extended
//   in_port               - asynchronous external inputs (WIDTH bits)
//   irq                   - level interrupt, OR of edge capture & mask
// Configuration macro: PIO_IN_DEBOUNCE_EN (enables per-bit debounce counters)
module candy_avb_test_qsys_pio_in
  import candy_avb_pio_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned StartW = startup_cnt_w(SYNC_STAGES);
  localparam logic [StartW-1:0] StartDone = StartW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  w_filt;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_edge_d;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  r_edge;
  logic [StartW-1:0] r_start;
  logic              w_wr;
  logic              w_det_en;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    candy_avb_pio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef PIO_IN_DEBOUNCE_EN
      ,
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
`endif
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .i_async(in_port[gi]),
      .o_filt (w_filt[gi])
    );
  end

`ifndef PIO_IN_DEBOUNCE_EN
  localparam int unsigned unused_debounce_cnt = DEBOUNCE_CNT;
`endif

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign w_wr     = chipselect & ~write_n;
  // Stay blind until the reset-cleared chain and r_prev hold real input values,
  // so a level already high at reset release is not seen as an edge.
  assign w_det_en = (r_start == StartDone);

  always_comb begin
    w_rise   = w_det_en ? (w_filt & ~r_prev) : '0;
    w_edge_d = r_edge;
    if (w_wr && (address == ADDR_EDGE)) begin
      w_edge_d = r_edge & ~writedata[WIDTH-1:0];
    end
    // A new edge wins over a simultaneous clear.
    w_edge_d = w_edge_d | w_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_start <= '0;
    end else begin
      r_prev <= w_filt;
      r_edge <= w_edge_d;
      if (!w_det_en) begin
        r_start <= r_start + StartW'(1);
      end
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = w_filt;
      ADDR_MASK: readdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = r_edge;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_candy_avb_test_qsys_pio_in.sv
// tb_candy_avb_test_qsys_pio_in
//   Directed, table-driven bench for candy_avb_test_qsys_pio_in (WIDTH=2,
//   SYNC_STAGES=2, DEBOUNCE_CNT=4). Honours PIO_IN_DEBOUNCE_EN.
module tb_candy_avb_test_qsys_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  candy_avb_test_qsys_pio_in #(
    .WIDTH       (2),
    .SYNC_STAGES (2),
    .DEBOUNCE_CNT(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [1:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic run_table();
    vec_t v[$];
    // inputs held across the edge; expectations are for the state before it
    v.push_back('{"idle_data",      2'd0, 1'b0, 1'b1, 32'h0,        2'b00, 32'h0, 1'b0});
    v.push_back('{"mask_wr1",       2'd2, 1'b1, 1'b0, 32'h1,        2'b00, 32'h0, 1'b0});
    v.push_back('{"mask_rd1",       2'd2, 1'b0, 1'b1, 32'h0,        2'b01, 32'h1, 1'b0});
    v.push_back('{"data_lat1",      2'd0, 1'b0, 1'b1, 32'h0,        2'b01, 32'h0, 1'b0});
    v.push_back('{"data_lat2",      2'd0, 1'b0, 1'b1, 32'h0,        2'b01, 32'h1, 1'b0});
    v.push_back('{"edge_set_b0",    2'd3, 1'b0, 1'b1, 32'h0,        2'b01, 32'h1, 1'b1});
    v.push_back('{"edge_w1c_b0",    2'd3, 1'b1, 1'b0, 32'h1,        2'b01, 32'h1, 1'b1});
    v.push_back('{"edge_clr_b0",    2'd3, 1'b0, 1'b1, 32'h0,        2'b01, 32'h0, 1'b0});
    v.push_back('{"mask_wr0",       2'd2, 1'b1, 1'b0, 32'h0,        2'b01, 32'h1, 1'b0});
    v.push_back('{"mask_rd0",       2'd2, 1'b0, 1'b1, 32'h0,        2'b11, 32'h0, 1'b0});
    v.push_back('{"data_b1_lat1",   2'd0, 1'b0, 1'b1, 32'h0,        2'b11, 32'h1, 1'b0});
    v.push_back('{"data_b1_lat2",   2'd0, 1'b0, 1'b1, 32'h0,        2'b11, 32'h3, 1'b0});
    v.push_back('{"edge_b1_masked", 2'd3, 1'b0, 1'b1, 32'h0,        2'b11, 32'h2, 1'b0});
    v.push_back('{"mask_wr2",       2'd2, 1'b1, 1'b0, 32'h2,        2'b11, 32'h0, 1'b0});
    v.push_back('{"mask_rd2",       2'd2, 1'b0, 1'b1, 32'h0,        2'b11, 32'h2, 1'b1});
    v.push_back('{"rsvd_wr",        2'd1, 1'b1, 1'b0, 32'hffffffff, 2'b11, 32'h0, 1'b1});
    v.push_back('{"data_wr",        2'd0, 1'b1, 1'b0, 32'h0,        2'b11, 32'h3, 1'b1});
    v.push_back('{"data_ro",        2'd0, 1'b0, 1'b1, 32'h0,        2'b11, 32'h3, 1'b1});
    v.push_back('{"rsvd_rd",        2'd1, 1'b0, 1'b1, 32'h0,        2'b11, 32'h0, 1'b1});
    v.push_back('{"nocs_clr",       2'd3, 1'b0, 1'b0, 32'h3,        2'b11, 32'h2, 1'b1});
    v.push_back('{"nocs_kept",      2'd3, 1'b0, 1'b1, 32'h0,        2'b11, 32'h2, 1'b1});
    v.push_back('{"edge_w1c_b1",    2'd3, 1'b1, 1'b0, 32'h2,        2'b11, 32'h2, 1'b1});
    v.push_back('{"edge_clr_b1",    2'd3, 1'b0, 1'b1, 32'h0,        2'b11, 32'h0, 1'b0});
    v.push_back('{"fall_lat0",      2'd0, 1'b0, 1'b1, 32'h0,        2'b00, 32'h3, 1'b0});
    v.push_back('{"fall_lat1",      2'd0, 1'b0, 1'b1, 32'h0,        2'b00, 32'h3, 1'b0});
    v.push_back('{"fall_lat2",      2'd0, 1'b0, 1'b1, 32'h0,        2'b00, 32'h0, 1'b0});
    v.push_back('{"fall_no_edge",   2'd3, 1'b0, 1'b1, 32'h0,        2'b00, 32'h0, 1'b0});
    foreach (v[i]) begin
      address    = v[i].addr;
      chipselect = v[i].cs;
      write_n    = v[i].wn;
      writedata  = v[i].wd;
      in_port    = v[i].inp;
      #1;
      check({v[i].name, "_rd"}, readdata, v[i].exp_rd);
      chk_irq(v[i].exp_irq, {v[i].name, "_irq"});
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 2'b11;
    repeat (2) tick();
    rd(2'd0, 32'h0, "rst_data");
    chk_irq(1'b0, "rst_irq");

`ifdef PIO_IN_DEBOUNCE_EN
    in_port = 2'b00;
    reset_n = 1'b1;
    repeat (4) tick();
    wr(2'd2, 32'h1);
    // 3-clock glitch must be swallowed
    in_port = 2'b01;
    repeat (3) tick();
    in_port = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      rd(2'd0, 32'h0, "glitch_data");
    end
    rd(2'd3, 32'h0, "glitch_edge");
    // 6-clock pulse passes at clock 6
    in_port = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(2'd0, (k == 6) ? 32'h1 : 32'h0, "pulse_data");
    end
    in_port = 2'b00;
    tick();
    rd(2'd3, 32'h1, "pulse_edge");
    chk_irq(1'b1, "pulse_irq");
    #1;
    reset_n = 1'b0;
    #1;
    chk_irq(1'b0, "deb_rst_irq");
    rd(2'd3, 32'h0, "deb_rst_edge");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    rd(2'd3, 32'h0, "deb_post_edge");
    rd(2'd2, 32'h0, "deb_post_mask");
`else
    // level high at reset release: data follows, no capture
    reset_n = 1'b1;
    tick();
    rd(2'd0, 32'h0, "start_lat1");
    tick();
    rd(2'd0, 32'h3, "start_lat2");
    tick();
    rd(2'd0, 32'h3, "start_data3");
    rd(2'd3, 32'h0, "start_edge3");
    chk_irq(1'b0, "start_irq3");
    repeat (2) tick();
    rd(2'd3, 32'h0, "start_edge5");
    in_port = 2'b00;
    repeat (3) tick();
    rd(2'd0, 32'h0, "settle_data");
    rd(2'd3, 32'h0, "settle_edge");

    run_table();

    // rising edge on bit 1 coincides with its write-1-to-clear
    in_port = 2'b10;
    repeat (3) tick();
    rd(2'd3, 32'h2, "pre_edge_b1");
    in_port = 2'b00;
    repeat (2) tick();
    rd(2'd0, 32'h0, "b1_fell");
    in_port = 2'b10;
    repeat (2) tick();
    rd(2'd0, 32'h2, "b1_rose");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h2, "rise_beats_clr");
    chk_irq(1'b1, "rise_beats_clr_irq");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "plain_clr_b1");
    chk_irq(1'b0, "plain_clr_b1_irq");

    // pending bit 0 with mask 0, then unmask
    wr(2'd2, 32'h0);
    in_port = 2'b11;
    repeat (3) tick();
    rd(2'd3, 32'h1, "pend_edge_b0");
    chk_irq(1'b0, "pend_masked_irq");
    wr(2'd2, 32'h1);
    chk_irq(1'b1, "unmask_irq");

    // reset pulse with edge=3, mask=3
    in_port = 2'b00;
    repeat (3) tick();
    in_port = 2'b11;
    repeat (3) tick();
    wr(2'd2, 32'h3);
    rd(2'd3, 32'h3, "pre_rst_edge");
    chk_irq(1'b1, "pre_rst_irq");
    #2;
    reset_n = 1'b0;
    #1;
    chk_irq(1'b0, "async_rst_irq");
    rd(2'd0, 32'h0, "in_rst_data");
    rd(2'd2, 32'h0, "in_rst_mask");
    rd(2'd3, 32'h0, "in_rst_edge");
    tick();
    reset_n = 1'b1;
    rd(2'd0, 32'h0, "post_rst_data");
    rd(2'd3, 32'h0, "post_rst_edge");
    chk_irq(1'b0, "post_rst_irq");
    repeat (5) tick();
    rd(2'd0, 32'h3, "post_rst_data5");
    rd(2'd2, 32'h0, "post_rst_mask5");
    rd(2'd3, 32'h0, "post_rst_edge5");
    chk_irq(1'b0, "post_rst_irq5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
